// File: rtl/fpu_op_sequencer_if.sv
// Request/response channel bundle between a requester and fpu_op_sequencer.
interface fpu_op_sequencer_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 2;

    logic              req_valid;
    logic              req_ready;
    logic              req_sp_dp;
    logic [OP_W-1:0]   req_opcode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_overflow;
    logic              rsp_underflow;
    logic              rsp_sp_dp;

    // Requester / response consumer side
    modport master (
        output req_valid, req_sp_dp, req_opcode, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow, rsp_sp_dp
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_sp_dp, req_opcode, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_underflow, rsp_sp_dp
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Sequential front-end for the combinational fpu: accepts one op, holds the
// operands stable for a fixed settle interval (multicycle paths), captures the
// result into a held response and tracks sticky flags and a completion count.
module fpu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    fpu_op_sequencer_if.slave bus,

    output logic              fpu_sp_dp,
    output logic [1:0]        fpu_opcode,
    output logic [31:0]       fpu_a_sp,
    output logic [31:0]       fpu_b_sp,
    output logic [63:0]       fpu_a_dp,
    output logic [63:0]       fpu_b_dp,
    input  logic [31:0]       fpu_result_sp,
    input  logic [63:0]       fpu_result_dp,
    input  logic              fpu_overflow,
    input  logic              fpu_underflow,

    output logic              sticky_overflow,
    output logic              sticky_underflow,
    input  logic              clear_sticky,
    output logic [CNT_W-1:0]  op_count
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned SP_W   = 32;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned SET_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [SET_W-1:0]  r_settle;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_fpu_sp_dp;
    logic [OP_W-1:0]   r_fpu_opcode;
    logic [DATA_W-1:0] r_fpu_a;
    logic [DATA_W-1:0] r_fpu_b;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_overflow;
    logic              r_rsp_underflow;
    logic              r_rsp_sp_dp;
    logic              r_sticky_overflow;
    logic              r_sticky_underflow;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_capture;
    logic [DATA_W-1:0] w_result_sel;

    assign w_capture    = (r_state == S_WAIT) && (r_settle == '0);
    assign w_result_sel = r_fpu_sp_dp ? fpu_result_dp : {{(DATA_W-SP_W){1'b0}}, fpu_result_sp};

    // Sequencer FSM: accept, settle countdown, held response, completion count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_settle        <= '0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_fpu_sp_dp     <= 1'b0;
            r_fpu_opcode    <= '0;
            r_fpu_a         <= '0;
            r_fpu_b         <= '0;
            r_rsp_result    <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
            r_rsp_sp_dp     <= 1'b0;
            r_op_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_fpu_sp_dp  <= bus.req_sp_dp;
                        r_fpu_opcode <= bus.req_opcode;
                        r_fpu_a      <= bus.req_a;
                        r_fpu_b      <= bus.req_b;
                        r_settle     <= SET_W'(SETTLE_CYCLES - 1);
                        r_req_ready  <= 1'b0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_settle == '0) begin
                        r_rsp_result    <= w_result_sel;
                        r_rsp_overflow  <= fpu_overflow;
                        r_rsp_underflow <= fpu_underflow;
                        r_rsp_sp_dp     <= r_fpu_sp_dp;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_settle <= r_settle - SET_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a capture wins over clear so a coincident new event survives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_overflow  <= 1'b0;
            r_sticky_underflow <= 1'b0;
        end else if (w_capture) begin
            r_sticky_overflow  <= fpu_overflow  | (r_sticky_overflow  & ~clear_sticky);
            r_sticky_underflow <= fpu_underflow | (r_sticky_underflow & ~clear_sticky);
        end else if (clear_sticky) begin
            r_sticky_overflow  <= 1'b0;
            r_sticky_underflow <= 1'b0;
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_overflow  = r_rsp_overflow;
    assign bus.rsp_underflow = r_rsp_underflow;
    assign bus.rsp_sp_dp     = r_rsp_sp_dp;

    assign fpu_sp_dp  = r_fpu_sp_dp;
    assign fpu_opcode = r_fpu_opcode;
    assign fpu_a_sp   = r_fpu_a[SP_W-1:0];
    assign fpu_b_sp   = r_fpu_b[SP_W-1:0];
    assign fpu_a_dp   = r_fpu_a;
    assign fpu_b_dp   = r_fpu_b;

    assign sticky_overflow  = r_sticky_overflow;
    assign sticky_underflow = r_sticky_underflow;
    assign op_count         = r_op_count;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer with a behavioural fpu stand-in.
module tb_fpu_op_sequencer;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear_sticky;
    logic             fpu_sp_dp;
    logic [1:0]       fpu_opcode;
    logic [31:0]      fpu_a_sp, fpu_b_sp;
    logic [63:0]      fpu_a_dp, fpu_b_dp;
    logic [31:0]      fpu_result_sp;
    logic [63:0]      fpu_result_dp;
    logic             fpu_overflow, fpu_underflow;
    logic             sticky_overflow, sticky_underflow;
    logic [CNT_W-1:0] op_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_done = 0;
    logic m_sov = 1'b0;
    logic m_sun = 1'b0;

    logic [31:0] sp_tab [0:7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hC0A00000,
                                  32'h3F000000, 32'h7F000000, 32'h00800000, 32'h42C80000};
    logic [63:0] dp_tab [0:6] = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000,
                                  64'hC014000000000000, 64'h3FE0000000000000, 64'h7FE0000000000000,
                                  64'h0010000000000000};

    always #5 clk = ~clk;

    fpu_op_sequencer_if bus();

    fpu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fpu_sp_dp(fpu_sp_dp), .fpu_opcode(fpu_opcode),
        .fpu_a_sp(fpu_a_sp), .fpu_b_sp(fpu_b_sp), .fpu_a_dp(fpu_a_dp), .fpu_b_dp(fpu_b_dp),
        .fpu_result_sp(fpu_result_sp), .fpu_result_dp(fpu_result_dp),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow),
        .clear_sticky(clear_sticky), .op_count(op_count)
    );

    // Single-precision bits to real (normal numbers; zero exponent treated as zero)
    function automatic real sp2real(input logic [31:0] v);
        logic [63:0] d;
        if (v[30:23] == 8'h00) return 0.0;
        d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    // Reference fpu: returns {overflow, underflow, 64-bit result}
    function automatic logic [65:0] fpu_calc(input logic dp, input logic [1:0] op,
                                             input logic [63:0] a, input logic [63:0] b);
        real x, y, r;
        logic [63:0] db, res;
        logic ovf, unf;
        int se;
        ovf = 1'b0;
        unf = 1'b0;
        if (dp) begin
            x = $bitstoreal(a);
            y = $bitstoreal(b);
        end else begin
            x = sp2real(a[31:0]);
            y = sp2real(b[31:0]);
        end
        case (op)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = x / y;
        endcase
        db = $realtobits(r);
        if (dp) begin
            res = db;
            ovf = (db[62:52] == 11'h7FF);
            unf = (db[62:52] == 11'h000) && (db[51:0] != 52'h0);
        end else if (db[62:52] == 11'h000) begin
            res = 64'h0;
        end else begin
            se = int'(db[62:52]) - 896;
            if (se >= 255) begin
                ovf = 1'b1;
                res = {32'h0, db[63], 8'hFF, 23'h0};
            end else if (se <= 0) begin
                unf = 1'b1;
                res = {32'h0, db[63], 31'h0};
            end else begin
                res = {32'h0, db[63], 8'(se), db[51:29]};
            end
        end
        return {ovf, unf, res};
    endfunction

    logic [65:0] w_sp_calc, w_dp_calc;
    always_comb begin
        w_sp_calc     = fpu_calc(1'b0, fpu_opcode, {32'h0, fpu_a_sp}, {32'h0, fpu_b_sp});
        w_dp_calc     = fpu_calc(1'b1, fpu_opcode, fpu_a_dp, fpu_b_dp);
        fpu_result_sp = w_sp_calc[31:0];
        fpu_result_dp = w_dp_calc[63:0];
        fpu_overflow  = fpu_sp_dp ? w_dp_calc[65] : w_sp_calc[65];
        fpu_underflow = fpu_sp_dp ? w_dp_calc[64] : w_sp_calc[64];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete op from the requester's view; called at a negedge, returns at a negedge
    task automatic run_op(input logic dp, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int hold, input bit clr_cap, input bit busy);
        logic [65:0] e;
        int waits;
        e = fpu_calc(dp, op, a, b);
        bus.req_valid  = 1'b1;
        bus.req_sp_dp  = dp;
        bus.req_opcode = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.rsp_ready  = (hold == 0);
        waits = 0;
        while (bus.req_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", 64'(waits), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = busy;
        bus.req_a     = ~a;
        bus.req_b     = ~b;
        bus.req_sp_dp = ~dp;
        check("fpu_sp_dp", 64'(fpu_sp_dp), 64'(dp));
        check("fpu_opcode", 64'(fpu_opcode), 64'(op));
        check("fpu_a_dp", fpu_a_dp, a);
        check("fpu_b_dp", fpu_b_dp, b);
        check("fpu_a_sp", 64'(fpu_a_sp), 64'(a[31:0]));
        check("fpu_b_sp", 64'(fpu_b_sp), 64'(b[31:0]));
        check("req_ready_busy", 64'(bus.req_ready), 64'd0);
        for (int k = 1; k <= int'(SETTLE); k++) begin
            if (k == int'(SETTLE)) clear_sticky = clr_cap;
            @(posedge clk);
            @(negedge clk);
            clear_sticky = 1'b0;
            check("rsp_valid_timing", 64'(bus.rsp_valid), 64'(k == int'(SETTLE)));
        end
        m_sov = e[65] | (m_sov & ~clr_cap);
        m_sun = e[64] | (m_sun & ~clr_cap);
        check("rsp_result", bus.rsp_result, e[63:0]);
        check("rsp_overflow", 64'(bus.rsp_overflow), 64'(e[65]));
        check("rsp_underflow", 64'(bus.rsp_underflow), 64'(e[64]));
        check("rsp_sp_dp", 64'(bus.rsp_sp_dp), 64'(dp));
        check("sticky_overflow", 64'(sticky_overflow), 64'(m_sov));
        check("sticky_underflow", 64'(sticky_underflow), 64'(m_sun));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_rsp_result", bus.rsp_result, e[63:0]);
            check("hold_rsp_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'(e[65:64]));
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            check("hold_fpu_a_dp", fpu_a_dp, a);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_done++;
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_req_ready", 64'(bus.req_ready), 64'd1);
        check("op_count", 64'(op_count), 64'(n_done % (1 << CNT_W)));
    endtask

    initial begin
        rst            = 1'b1;
        clear_sticky   = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_sp_dp  = 1'b0;
        bus.req_opcode = 2'd0;
        bus.req_a      = 64'h0;
        bus.req_b      = 64'h0;
        bus.rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_result", bus.rsp_result, 64'h0);
        check("rst_fpu_a_dp", fpu_a_dp, 64'h0);
        check("rst_fpu_ctl", 64'({fpu_sp_dp, fpu_opcode}), 64'd0);
        check("rst_sticky", 64'({sticky_overflow, sticky_underflow}), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);

        // Reset while in WAIT discards the op
        bus.req_valid  = 1'b1;
        bus.req_sp_dp  = 1'b0;
        bus.req_opcode = 2'd2;
        bus.req_a      = 64'h7F000000;
        bus.req_b      = 64'h7F000000;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_in_wait", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_req_ready", 64'(bus.req_ready), 64'd1);
        check("mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_op_count", 64'(op_count), 64'd0);
        check("mid_fpu_a_dp", fpu_a_dp, 64'h0);
        check("mid_sticky", 64'({sticky_overflow, sticky_underflow}), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        // Directed ops
        run_op(1'b0, 2'd0, 64'h3F800000, 64'h40000000, 0, 1'b0, 1'b0);
        check("sp_add_value", bus.rsp_result, 64'h0000000040400000);
        run_op(1'b1, 2'd2, 64'h4000000000000000, 64'h4008000000000000, 0, 1'b0, 1'b0);
        check("dp_mul_value", bus.rsp_result, 64'h4018000000000000);
        run_op(1'b0, 2'd2, 64'h7F000000, 64'h7F000000, 0, 1'b0, 1'b0);
        check("ovf_rsp_flag", 64'(bus.rsp_overflow), 64'd1);
        run_op(1'b0, 2'd0, 64'h3F800000, 64'h3F800000, 0, 1'b0, 1'b0);
        check("ovf_persist", 64'({sticky_overflow, bus.rsp_overflow}), 64'b10);
        run_op(1'b0, 2'd2, 64'hDEADBEEF7F000000, 64'h7F000000, 0, 1'b1, 1'b0);
        check("clr_at_capture", 64'(sticky_overflow), 64'd1);

        // Clear outside a capture
        clear_sticky = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_sticky = 1'b0;
        m_sov = 1'b0;
        m_sun = 1'b0;
        check("clr_idle", 64'({sticky_overflow, sticky_underflow}), 64'd0);

        // Backpressure with a new request held pending, then accepted right after
        run_op(1'b1, 2'd3, 64'h4008000000000000, 64'h3FE0000000000000, 5, 1'b0, 1'b1);
        run_op(1'b0, 2'd1, 64'h40400000, 64'h3F800000, 0, 1'b0, 1'b0);

        // Random ops; op_count wraps through 15 -> 0 -> 1 here
        for (int i = 0; i < 14; i++) begin
            logic dp;
            logic [63:0] a, b;
            dp = 1'($urandom_range(0, 1));
            if (dp) begin
                a = dp_tab[$urandom_range(0, 6)];
                b = dp_tab[$urandom_range(0, 6)];
            end else begin
                a = {$urandom(), sp_tab[$urandom_range(0, 7)]};
                b = {$urandom(), sp_tab[$urandom_range(0, 7)]};
            end
            run_op(dp, 2'($urandom_range(0, 3)), a, b, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        check("final_count", 64'(n_done), 64'd21);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
